// File: rtl/board_input_reader_pkg.sv
// rtl/board_input_reader_pkg.sv - shared defaults and counter sizing for the board input reader
package board_input_reader_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int NUM_BTN_DEFAULT         = 4;
   localparam int NUM_SW_DEFAULT          = 8;

   // Counter only has to reach DEBOUNCE_CYCLES-1, so $clog2 is exactly wide enough.
   function automatic int cnt_width(input int debounce_cycles);
      return $clog2(debounce_cycles);
   endfunction

endpackage

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - one pin: 2-flop synchronizer, stability counter, debounced level and edge pulses
module input_debouncer
   import board_input_reader_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin_raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int              CW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          stable;
   logic [CW-1:0] cnt;
   logic          accept;

   assign accept = (sync2 != stable) && (cnt == CNT_MAX);
   assign level  = stable;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync1 <= pin_raw;
         sync2 <= sync1;
         // Pulses are registered on the same edge that flips stable.
         rise  <= accept & sync2;
         fall  <= accept & ~sync2;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (accept) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/board_input_reader.sv
// rtl/board_input_reader.sv - debounced pushbutton and slide-switch capture with event pulses
module board_input_reader
   import board_input_reader_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int NUM_BTN         = NUM_BTN_DEFAULT,
   parameter int NUM_SW          = NUM_SW_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_raw,
   input  logic [NUM_SW-1:0]  sw_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_SW-1:0]  sw_level,
   output logic               sw_changed
);

   logic [NUM_SW-1:0] sw_rise;
   logic [NUM_SW-1:0] sw_fall;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk     (clk),
         .rst_n   (rst_n),
         .pin_raw (btn_raw[i]),
         .level   (btn_level[i]),
         .rise    (btn_press[i]),
         .fall    (btn_release[i])
      );
   end

   for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
      input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk     (clk),
         .rst_n   (rst_n),
         .pin_raw (sw_raw[i]),
         .level   (sw_level[i]),
         .rise    (sw_rise[i]),
         .fall    (sw_fall[i])
      );
   end

   // Per-switch pulses come straight from flops, so their OR lines up with sw_level.
   assign sw_changed = |(sw_rise | sw_fall);

endmodule

// File: doc/board_input_reader.md
# board_input_reader

Captures the board's physical pushbuttons and slide switches and presents clean, synchronous values and event pulses to the CPU core. Each raw pin is synchronized, then debounced by a per-pin stability counter. Buttons additionally produce one-cycle press and release pulses. This block is the input-side counterpart of the LED/seven-segment display driver: the display driver pushes state out to the board, and this block pulls state in from it.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz). Legal values are ≥ 2.
- NUM_BTN, default 4: number of pushbuttons.
- NUM_SW, default 8: number of slide switches.

Ports:
- clk, input, 1: the only clock. All state updates on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- btn_raw, input, NUM_BTN: raw pushbutton pins. Active-high, asynchronous to clk.
- sw_raw, input, NUM_SW: raw switch pins. Asynchronous to clk.
- btn_level, output, NUM_BTN: debounced button levels.
- btn_press, output, NUM_BTN: one-cycle pulse when a debounced button goes 0→1.
- btn_release, output, NUM_BTN: one-cycle pulse when a debounced button goes 1→0.
- sw_level, output, NUM_SW: debounced switch levels.
- sw_changed, output, 1: one-cycle pulse when any sw_level bit changes.

## Operation
Each pin has its own state:
- sync1 and sync2: a 2-flop synchronizer.
- stable: the accepted, debounced level.
- cnt: a counter of width $clog2(DEBOUNCE_CYCLES).

Every cycle, each pin updates as follows:
- If sync2 == stable, cnt is set to 0.
- Otherwise, if cnt == DEBOUNCE_CYCLES-1, then stable ← sync2 and cnt ← 0.
- Otherwise, cnt ← cnt+1.

Behaviour that follows from this rule:
- Any glitch or bounce that returns to the stable level before DEBOUNCE_CYCLES mismatch cycles restarts the count. No partial credit carries over.
- cnt never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.

Outputs:
- btn_level and sw_level are the stable bits themselves.
- btn_press[i], btn_release[i] and sw_changed are registered. They assert in the same cycle the corresponding stable bit changes, for exactly one cycle.
- If several buttons change on the same edge, each fires its own pulse in that cycle.
- If several switches change on the same edge, sw_changed is a single one-cycle pulse.
- A press and a release on the same bit in the same cycle is impossible by construction.

Reset:
- While rst_n = 0, all sync flops, stable bits, counters and all outputs are 0, including every pulse output.
- Asserting rst_n mid-count discards any partial count.
- After release, a pin already held at 1 is treated as a new 0→1 transition. It produces btn_press (or sw_changed) after the normal latency.

## Timing
- Let edge N be the first rising edge that samples the new raw level into sync1.
- sync2 takes the new level at edge N+1.
- Mismatch cycles are counted at edges N+2 … N+DEBOUNCE_CYCLES.
- stable and the pulse outputs update at edge N+1+DEBOUNCE_CYCLES. The new value is visible in the following cycle.
- Fixed latency from raw change to output is DEBOUNCE_CYCLES+2 clocks, with up to one extra cycle of synchronizer uncertainty.
- A pulse is high for exactly one clock period. There is no handshake: consumers must sample every cycle.
- Minimum spacing between two accepted transitions on one pin is DEBOUNCE_CYCLES cycles.

## Structure
- The shared package holds:
  - DEFAULT_DEBOUNCE_CYCLES = 500000
  - NUM_BTN_DEFAULT = 4
  - NUM_SW_DEFAULT = 8
  - a function computing counter width from DEBOUNCE_CYCLES
- Sub-module input_debouncer contains one pin's synchronizer, counter and stable flop, plus rise/fall pulse outputs. It is parameterized by DEBOUNCE_CYCLES.
- The top instantiates NUM_BTN+NUM_SW copies of input_debouncer.
- sw_changed is the registered OR of the switch rise/fall pulses, aligned so it asserts in the same cycle as the sw_level change.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4.
1. Reset and idle: hold rst_n=0, then release with all raw inputs 0. Required: all outputs stay 0 for 20 cycles.
2. Clean press: btn_raw[0] 0→1 sampled at edge N. Required: btn_level[0]=1 and btn_press[0]=1 at edge N+5. btn_press[0] returns to 0 at edge N+6. btn_release stays 0 throughout.
3. Bounce rejection: btn_raw[1] toggles 1,0,1,0 with each level held 3 cycles, then stays 0. Required: btn_level[1] and btn_press[1] never assert. Follow-on check: hold btn_raw[1]=1 for 4 or more sync cycles. Required: exactly one btn_press[1] pulse.
4. Simultaneous switches: sw_raw goes 0x00→0x81 on one edge. Required: sw_level=0x81 after 6 edges, and sw_changed is one single-cycle pulse.
5. Reset mid-count: press btn_raw[2] and assert rst_n after 3 mismatch cycles, holding btn_raw[2]=1 throughout. Required: outputs go 0 immediately. After rst_n rises, btn_press[2] fires after 6 edges.
6. Release with concurrent press: btn_raw[3] 1→0 and btn_raw[0] 0→1 on the same edge. Required: btn_release[3] and btn_press[0] both pulse in the same cycle.
